// File: rtl/cnn_pixel_streamer_if.sv
// rtl/cnn_pixel_streamer_if.sv - host write port, start control and pixel stream signals of the streamer
// loop_en exists only when STREAM_LOOP_EN is defined.
interface cnn_pixel_streamer_if #(
   parameter int BitSize = 32,
   parameter int AW      = 6
);
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [BitSize-1:0] wr_data;
   logic               start;
   logic               in_ready;
   logic               out_valid;
   logic [BitSize-1:0] out_data;
   logic               out_last;
   logic               busy;
   logic               done;
   logic               wr_err;
`ifdef STREAM_LOOP_EN
   logic               loop_en;

   modport master (
      output wr_en, wr_addr, wr_data, start, in_ready, loop_en,
      input  out_valid, out_data, out_last, busy, done, wr_err
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, start, in_ready, loop_en,
      output out_valid, out_data, out_last, busy, done, wr_err
   );
`else
   modport master (
      output wr_en, wr_addr, wr_data, start, in_ready,
      input  out_valid, out_data, out_last, busy, done, wr_err
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, start, in_ready,
      output out_valid, out_data, out_last, busy, done, wr_err
   );
`endif
endinterface

// File: rtl/cnn_pixel_streamer.sv
// rtl/cnn_pixel_streamer.sv - frame buffer streamed in raster order, one pixel per CyclesPerPixel slot
// Optional STREAM_LOOP_EN replays the buffered frame back to back while loop_en is high.
module cnn_pixel_streamer #(
   parameter int BitSize        = 32,
   parameter int ImageWidth     = 8,
   parameter int CyclesPerPixel = 2
) (
   input logic                 clk,
   input logic                 res_n,
   cnn_pixel_streamer_if.slave bus
);
   localparam int NPix = ImageWidth * ImageWidth;
   localparam int AW   = $clog2(NPix);
   localparam int GW   = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1;
   localparam logic [AW:0] NPixW = (AW+1)'(NPix);

   typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

   state_t             state, state_nxt;
   logic [AW-1:0]      pix_cnt, pix_cnt_nxt;
   logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
   logic               start_q;
   logic               out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
   logic [BitSize-1:0] out_data_nxt;
   logic [BitSize-1:0] mem [NPix];
   logic               last_pix;
   logic               loop;

`ifdef STREAM_LOOP_EN
   assign loop = bus.loop_en;
`else
   assign loop = 1'b0;
`endif

   assign last_pix = (pix_cnt == AW'(NPix - 1));

   always_ff @(posedge clk) begin
      if (bus.wr_en && !bus.busy && ({1'b0, bus.wr_addr} < NPixW))
         mem[bus.wr_addr] <= bus.wr_data;
   end

   // start is registered once so the first pixel leaves two edges after start is sampled
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state         <= IDLE;
         pix_cnt       <= '0;
         gap_cnt       <= '0;
         start_q       <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.wr_err    <= 1'b0;
      end else begin
         state         <= state_nxt;
         pix_cnt       <= pix_cnt_nxt;
         gap_cnt       <= gap_cnt_nxt;
         start_q       <= bus.start && (state == IDLE);
         bus.out_valid <= out_valid_nxt;
         bus.out_data  <= out_data_nxt;
         bus.out_last  <= out_last_nxt;
         bus.busy      <= busy_nxt;
         bus.done      <= done_nxt;
         bus.wr_err    <= bus.wr_err | (bus.wr_en & bus.busy);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_q) state_nxt = STREAM;
         STREAM:  if (bus.in_ready) begin
                     if (last_pix)                state_nxt = DONE;
                     else if (CyclesPerPixel > 1) state_nxt = GAP;
                  end
         GAP:     if (gap_cnt == GW'(1)) state_nxt = STREAM;
         DONE:    state_nxt = loop ? STREAM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pix_cnt_nxt   = pix_cnt;
      gap_cnt_nxt   = gap_cnt;
      out_valid_nxt = 1'b0;
      out_data_nxt  = bus.out_data;
      out_last_nxt  = bus.out_last;
      busy_nxt      = bus.busy;
      done_nxt      = 1'b0;
      case (state)
         IDLE: if (start_q) begin
            busy_nxt    = 1'b1;
            pix_cnt_nxt = '0;
         end
         STREAM: if (bus.in_ready) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = mem[pix_cnt];
            out_last_nxt  = last_pix;
            if (!last_pix) begin
               pix_cnt_nxt = pix_cnt + 1'b1;
               gap_cnt_nxt = GW'(CyclesPerPixel - 1);
            end
         end
         GAP: gap_cnt_nxt = gap_cnt - 1'b1;
         DONE: begin
            out_last_nxt = 1'b0;
            done_nxt     = 1'b1;
            if (loop) pix_cnt_nxt = '0;
            else      busy_nxt    = 1'b0;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// tb/tb_cnn_pixel_streamer.sv - scoreboard bench for cnn_pixel_streamer (CyclesPerPixel 2 and 1 instances)
// Defining STREAM_LOOP_EN adds the back-to-back replay scenario.
module tb_cnn_pixel_streamer;
   localparam int BS   = 32;
   localparam int IW   = 4;
   localparam int NPIX = IW * IW;
   localparam int AW   = 4;

   typedef struct {logic [BS-1:0] data; logic last; int cyc;} pix_t;
   typedef struct {int cyc; logic busy;} done_t;

   logic clk = 1'b0;
   logic res_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   sel1 = 1'b0;
   logic [BS-1:0] img [NPIX];
   pix_t  exp_q [$];
   done_t done_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cnn_pixel_streamer_if #(.BitSize(BS), .AW(AW)) bus2 ();
   cnn_pixel_streamer_if #(.BitSize(BS), .AW(AW)) bus1 ();

   cnn_pixel_streamer #(.BitSize(BS), .ImageWidth(IW), .CyclesPerPixel(2)) u_dut2 (
      .clk(clk), .res_n(res_n), .bus(bus2));
   cnn_pixel_streamer #(.BitSize(BS), .ImageWidth(IW), .CyclesPerPixel(1)) u_dut1 (
      .clk(clk), .res_n(res_n), .bus(bus1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      pix_t p;
      done_t e;
      logic v, l, d, b;
      logic [BS-1:0] dat;
      v   = sel1 ? bus1.out_valid : bus2.out_valid;
      l   = sel1 ? bus1.out_last  : bus2.out_last;
      d   = sel1 ? bus1.done      : bus2.done;
      b   = sel1 ? bus1.busy      : bus2.busy;
      dat = sel1 ? bus1.out_data  : bus2.out_data;
      if (res_n) begin
         if (v) begin
            if (exp_q.size() == 0) check("spurious_valid", v, 0);
            else begin
               p = exp_q.pop_front();
               check("data", dat, p.data);
               check("last", l, p.last);
               check("issue_cyc", cyc, p.cyc);
            end
         end
         if (d) begin
            if (done_q.size() == 0) check("spurious_done", d, 0);
            else begin
               e = done_q.pop_front();
               check("done_cyc", cyc, e.cyc);
               check("busy_at_done", b, e.busy);
            end
         end
      end
   end

   task automatic wr(input bit s, input int a, input logic [BS-1:0] d);
      if (s) begin bus1.wr_en = 1'b1; bus1.wr_addr = a[AW-1:0]; bus1.wr_data = d; end
      else   begin bus2.wr_en = 1'b1; bus2.wr_addr = a[AW-1:0]; bus2.wr_data = d; end
      @(negedge clk);
      bus1.wr_en = 1'b0;
      bus2.wr_en = 1'b0;
   endtask

   // pixel k leaves at t+2+k*cpp plus any stall; done follows the last pixel by one cycle
   task automatic start_frame(input bit s, input int cpp, input int stall_at, input int stall_len,
                              input int frames, output int t);
      pix_t  p;
      done_t e;
      int    slot;
      t    = cyc + 1;
      slot = t + 2;
      for (int f = 0; f < frames; f++) begin
         for (int k = 0; k < NPIX; k++) begin
            if (f == 0 && k == stall_at) slot += stall_len;
            p.data = img[k];
            p.last = (k == NPIX - 1);
            p.cyc  = slot;
            exp_q.push_back(p);
            if (k == NPIX - 1) begin
               e.cyc  = slot + 1;
               e.busy = (f < frames - 1);
               done_q.push_back(e);
               slot += 2;
            end else begin
               slot += cpp;
            end
         end
      end
      if (s) bus1.start = 1'b1; else bus2.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      bus2.start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_in_time", n < budget, 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int t;
      bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.start = 1'b0; bus1.in_ready = 1'b1;
      bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.start = 1'b0; bus2.in_ready = 1'b1;
`ifdef STREAM_LOOP_EN
      bus1.loop_en = 1'b0;
      bus2.loop_en = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_valid", bus2.out_valid, 0);
      check("rst_data", bus2.out_data, 0);
      check("rst_last", bus2.out_last, 0);
      check("rst_busy", bus2.busy, 0);
      check("rst_done", bus2.done, 0);
      check("rst_wr_err", bus2.wr_err, 0);
      res_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NPIX; i++) begin
         img[i] = BS'(100 + i);
         wr(1'b0, i, img[i]);
      end

      // T1: plain frame
      start_frame(1'b0, 2, -1, 0, 1, t);
      while (cyc < t + 2) @(negedge clk);
      check("busy_streaming", bus2.busy, 1);
      wait_idle(200);
      check("wr_err_clean", bus2.wr_err, 0);
      check("busy_after", bus2.busy, 0);

      // T2: five stalled issue slots before pixel 4
      start_frame(1'b0, 2, 4, 5, 1, t);
      while (cyc < t + 9) @(negedge clk);
      bus2.in_ready = 1'b0;
      while (cyc < t + 14) @(negedge clk);
      bus2.in_ready = 1'b1;
      wait_idle(200);

      // T3: write while busy is dropped and flagged
      start_frame(1'b0, 2, -1, 0, 1, t);
      while (cyc < t + 5) @(negedge clk);
      wr(1'b0, 2, 32'hDEAD);
      check("wr_err_set", bus2.wr_err, 1);
      wait_idle(200);
      check("wr_err_sticky", bus2.wr_err, 1);

      // T4: asynchronous reset after pixel 7, then a fresh frame from the kept buffer
      start_frame(1'b0, 2, -1, 0, 1, t);
      while (cyc < t + 16) @(negedge clk);
      #1 res_n = 1'b0;
      #1;
      check("arst_valid", bus2.out_valid, 0);
      check("arst_busy", bus2.busy, 0);
      check("arst_done", bus2.done, 0);
      check("arst_wr_err", bus2.wr_err, 0);
      exp_q.delete();
      done_q.delete();
      #2 res_n = 1'b1;
      @(negedge clk);
      start_frame(1'b0, 2, -1, 0, 1, t);
      wait_idle(200);

      // T5: one pixel per cycle, second start while busy ignored
      sel1 = 1'b1;
      for (int i = 0; i < NPIX; i++) wr(1'b1, i, img[i]);
      start_frame(1'b1, 1, -1, 0, 1, t);
      while (cyc < t + 6) @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_idle(200);
      repeat (4) @(negedge clk);
      check("busy1_after", bus1.busy, 0);
      sel1 = 1'b0;

`ifdef STREAM_LOOP_EN
      // T6: two frames back to back
      bus2.loop_en = 1'b1;
      start_frame(1'b0, 2, -1, 0, 2, t);
      while (cyc < t + 34) @(negedge clk);
      check("busy_loop", bus2.busy, 1);
      bus2.loop_en = 1'b0;
      wait_idle(300);
      check("busy_loop_end", bus2.busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
